bisr_alloc_sequencer: RTL and testbench
=======================================

BISR_ALLOC_SEQUENCER -- requirements
Module: bisr_alloc_sequencer

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 4: rows/PEs per row of the array.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8: bits per weight.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: max WAIT_DONE cycles.
REQ-004 SHALL have localparam ADDR_WIDTH = $clog2(SYSTOLIC_SIZE).
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  host request pulse.
- buf_rd_en  out  1  weight-buffer read strobe.
- buf_rd_addr  out  ADDR_WIDTH  weight-buffer row address.
- buf_rd_data  in  SYSTOLIC_SIZE*WEIGHT_WIDTH  buffer data, valid 1 cycle after buf_rd_en.
- envm_wr_en  out  1  fault-map load strobe to allocator.
- weight_start  out  1  allocation start pulse to allocator.
- input_weights  out  SYSTOLIC_SIZE*WEIGHT_WIDTH  row to allocator.
- weight_valid  out  1  input_weights valid.
- recovery_done  in  1  allocator finished.
- recovery_success  in  1  allocator result, qualified by recovery_done.
- read_addr  out  ADDR_WIDTH  logical row read address to allocator.
- array_ready  in  1  systolic array accepts a row.
- row_load_valid  out  1  allocator output row is being loaded this cycle.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- fail  out  1  sticky failure flag.
- fail_code  out  2  00 none, 01 unrecoverable, 10 timeout.

Function
REQ-006 SHALL implement FSM states IDLE, ENVM_LOAD, ALLOC_START, STREAM, WAIT_DONE, READOUT, FINISH.
REQ-007 IDLE: start=1 -> ENVM_LOAD, clear fail/fail_code; start in any other state SHALL be ignored.
REQ-008 ENVM_LOAD SHALL last exactly 1 cycle with envm_wr_en=1, then -> ALLOC_START.
REQ-009 ALLOC_START SHALL last exactly 1 cycle with weight_start=1, then -> STREAM.
REQ-010 STREAM SHALL assert buf_rd_en for exactly SYSTOLIC_SIZE consecutive cycles, buf_rd_addr 0,1,..,SYSTOLIC_SIZE-1, then -> WAIT_DONE.
REQ-011 weight_valid SHALL be a register equal to buf_rd_en delayed 1 cycle; input_weights SHALL equal buf_rd_data when weight_valid=1 and zero otherwise, giving SYSTOLIC_SIZE contiguous valid cycles.
REQ-012 WAIT_DONE SHALL count cycles from 0; recovery_done=1 and recovery_success=1 -> READOUT.
REQ-013 WAIT_DONE: recovery_done=1 and recovery_success=0 -> FINISH with fail=1, fail_code=01, no readout.
REQ-014 WAIT_DONE: counter reaching TIMEOUT_CYCLES without recovery_done -> FINISH with fail=1, fail_code=10; recovery_done in the same cycle SHALL take priority over timeout.
REQ-015 recovery_done outside WAIT_DONE SHALL be ignored.
REQ-016 READOUT: row_load_valid = array_ready (combinational within READOUT, 0 elsewhere); read_addr SHALL hold while array_ready=0 and increment after each cycle with row_load_valid=1.
REQ-017 READOUT: row accepted at read_addr=SYSTOLIC_SIZE-1 -> FINISH; read_addr SHALL return to 0, with no wrap beyond SYSTOLIC_SIZE-1.
REQ-018 FINISH SHALL last 1 cycle with done=1, then -> IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 fail and fail_code SHALL hold until the next accepted start.
REQ-021 buf_rd_en, envm_wr_en, weight_start, weight_valid and done SHALL all be registered outputs.

Reset
REQ-022 rst=1 SHALL immediately force IDLE, with all outputs 0 and all counters 0, including mid-sequence.
REQ-023 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-024 SYSTOLIC_SIZE=4, start pulse, recovery_done=recovery_success=1 three cycles after last weight_valid, array_ready=1 -> envm_wr_en at cycle 1, weight_start at cycle 2, weight_valid cycles 4-7 carrying buffer rows 0-3, read_addr 0,1,2,3, done pulse, fail=0.
REQ-025 Same flow with recovery_success=0 -> no row_load_valid, done pulse, fail=1, fail_code=01.
REQ-026 recovery_done never asserted -> done exactly TIMEOUT_CYCLES(16) cycles after WAIT_DONE entry (+1 for FINISH), fail_code=10; recovery_done coincident with cycle 16 -> success path.
REQ-027 array_ready toggling 1,0,0,1,1,0,1 during READOUT -> read_addr sequence 0,1,1,1,2,3,3 then FINISH; exactly 4 row_load_valid cycles.
REQ-028 rst pulsed during STREAM (after 2 reads) -> all outputs 0 next sample; new start replays from buf_rd_addr 0; start pulsed while busy -> no effect.

Source files
------------

// File: rtl/bisr_alloc_sequencer.sv
// ============================================================================
// Module   : bisr_alloc_sequencer
// Purpose  : Sequences fault-map load, weight streaming, allocator handshake
//            and repaired-row readout for a built-in self-repair allocator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bisr_alloc_sequencer #(
    parameter int SYSTOLIC_SIZE  = 4,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic                                  buf_rd_en,
    output logic [ADDR_WIDTH-1:0]                 buf_rd_addr,
    input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] buf_rd_data,
    output logic                                  envm_wr_en,
    output logic                                  weight_start,
    output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] input_weights,
    output logic                                  weight_valid,
    input  logic                                  recovery_done,
    input  logic                                  recovery_success,
    output logic [ADDR_WIDTH-1:0]                 read_addr,
    input  logic                                  array_ready,
    output logic                                  row_load_valid,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  fail,
    output logic [1:0]                            fail_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
    localparam logic [CNT_W-1:0]      c_TIMEOUT   = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_ENVM_LOAD   = 3'd1;
    localparam logic [2:0] c_ALLOC_START = 3'd2;
    localparam logic [2:0] c_STREAM      = 3'd3;
    localparam logic [2:0] c_WAIT_DONE   = 3'd4;
    localparam logic [2:0] c_READOUT     = 3'd5;
    localparam logic [2:0] c_FINISH      = 3'd6;

    localparam logic [1:0] c_CODE_NONE    = 2'b00;
    localparam logic [1:0] c_CODE_UNRECOV = 2'b01;
    localparam logic [1:0] c_CODE_TIMEOUT = 2'b10;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;

    logic [ADDR_WIDTH-1:0] r_stream_cnt;
    logic [ADDR_WIDTH-1:0] r_read_addr;
    logic [CNT_W-1:0]      r_wait_cnt;

    logic                  r_buf_rd_en;
    logic                  r_envm_wr_en;
    logic                  r_weight_start;
    logic                  r_weight_valid;
    logic                  r_done;
    logic                  r_fail;
    logic [1:0]            r_fail_code;

    logic                  w_busy;
    logic                  w_row_load_valid;
    logic                  w_timeout;

    assign w_timeout = (r_wait_cnt == c_TIMEOUT);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next_state = c_ENVM_LOAD;
                end
            end
            c_ENVM_LOAD: begin
                w_next_state = c_ALLOC_START;
            end
            c_ALLOC_START: begin
                w_next_state = c_STREAM;
            end
            c_STREAM: begin
                if (r_stream_cnt == c_LAST_ADDR) begin
                    w_next_state = c_WAIT_DONE;
                end
            end
            c_WAIT_DONE: begin
                // An allocator answer in the timeout cycle still wins.
                if (recovery_done) begin
                    w_next_state = recovery_success ? c_READOUT : c_FINISH;
                end else if (w_timeout) begin
                    w_next_state = c_FINISH;
                end
            end
            c_READOUT: begin
                if (w_row_load_valid && (r_read_addr == c_LAST_ADDR)) begin
                    w_next_state = c_FINISH;
                end
            end
            c_FINISH: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy           = 1'b0;
        w_row_load_valid = 1'b0;
        if (r_state != c_IDLE) begin
            w_busy = 1'b1;
        end
        if (r_state == c_READOUT) begin
            w_row_load_valid = array_ready;
        end
    end

    // ------------------------------------------------------------------------
    // Registered strobes, decoded from the upcoming state so they line up
    // exactly with the state they belong to.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_envm_wr_en   <= 1'b0;
            r_weight_start <= 1'b0;
            r_buf_rd_en    <= 1'b0;
            r_weight_valid <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_envm_wr_en   <= (w_next_state == c_ENVM_LOAD);
            r_weight_start <= (w_next_state == c_ALLOC_START);
            r_buf_rd_en    <= (w_next_state == c_STREAM);
            r_weight_valid <= r_buf_rd_en;
            r_done         <= (w_next_state == c_FINISH);
        end
    end

    // ------------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stream_cnt <= '0;
        end else if (r_state == c_STREAM) begin
            if (r_stream_cnt == c_LAST_ADDR) begin
                r_stream_cnt <= '0;
            end else begin
                r_stream_cnt <= r_stream_cnt + ADDR_WIDTH'(1);
            end
        end else begin
            r_stream_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if ((r_state == c_WAIT_DONE) && (w_next_state == c_WAIT_DONE)) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_addr <= '0;
        end else if (w_row_load_valid) begin
            if (r_read_addr == c_LAST_ADDR) begin
                r_read_addr <= '0;
            end else begin
                r_read_addr <= r_read_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky failure status, cleared only by an accepted start
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fail      <= 1'b0;
            r_fail_code <= c_CODE_NONE;
        end else if ((r_state == c_IDLE) && start) begin
            r_fail      <= 1'b0;
            r_fail_code <= c_CODE_NONE;
        end else if (r_state == c_WAIT_DONE) begin
            if (recovery_done && !recovery_success) begin
                r_fail      <= 1'b1;
                r_fail_code <= c_CODE_UNRECOV;
            end else if (!recovery_done && w_timeout) begin
                r_fail      <= 1'b1;
                r_fail_code <= c_CODE_TIMEOUT;
            end
        end
    end

    assign busy           = w_busy;
    assign row_load_valid = w_row_load_valid;
    assign buf_rd_en      = r_buf_rd_en;
    assign buf_rd_addr    = r_stream_cnt;
    assign envm_wr_en     = r_envm_wr_en;
    assign weight_start   = r_weight_start;
    assign weight_valid   = r_weight_valid;
    assign input_weights  = r_weight_valid ? buf_rd_data : '0;
    assign read_addr      = r_read_addr;
    assign done           = r_done;
    assign fail           = r_fail;
    assign fail_code      = r_fail_code;

endmodule

`default_nettype wire

// File: tb/tb_bisr_alloc_sequencer.sv
// ============================================================================
// Module   : tb_bisr_alloc_sequencer
// Purpose  : Scoreboard bench for bisr_alloc_sequencer (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bisr_alloc_sequencer;

    localparam int SS = 4;
    localparam int WW = 8;
    localparam int TO = 16;
    localparam int AW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              buf_rd_en;
    logic [AW-1:0]     buf_rd_addr;
    logic [SS*WW-1:0]  buf_rd_data = '0;
    logic              envm_wr_en;
    logic              weight_start;
    logic [SS*WW-1:0]  input_weights;
    logic              weight_valid;
    logic              recovery_done = 1'b0;
    logic              recovery_success = 1'b0;
    logic [AW-1:0]     read_addr;
    logic              array_ready = 1'b0;
    logic              row_load_valid;
    logic              busy;
    logic              done;
    logic              fail;
    logic [1:0]        fail_code;

    int vec = 0;
    int err = 0;

    logic [SS*WW-1:0] mem [SS];
    logic [SS*WW-1:0] exp_q [$];

    int o_envm_cyc, o_envm_n, o_ws_cyc, o_ws_n, o_rd_first, n_rd;
    int o_wv_first, o_wv_last, n_wv, n_rlv, o_done_cyc, n_ra;
    int o_ra [16];
    logic       o_fail, o_fail_c1;
    logic [1:0] o_code, o_code_c1;

    bisr_alloc_sequencer #(
        .SYSTOLIC_SIZE  (SS),
        .WEIGHT_WIDTH   (WW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .buf_rd_en        (buf_rd_en),
        .buf_rd_addr      (buf_rd_addr),
        .buf_rd_data      (buf_rd_data),
        .envm_wr_en       (envm_wr_en),
        .weight_start     (weight_start),
        .input_weights    (input_weights),
        .weight_valid     (weight_valid),
        .recovery_done    (recovery_done),
        .recovery_success (recovery_success),
        .read_addr        (read_addr),
        .array_ready      (array_ready),
        .row_load_valid   (row_load_valid),
        .busy             (busy),
        .done             (done),
        .fail             (fail),
        .fail_code        (fail_code)
    );

    always #5 clk = ~clk;

    // Weight buffer: data appears one cycle after the read strobe
    always @(posedge clk) begin
        if (buf_rd_en) begin
            buf_rd_data <= mem[buf_rd_addr];
        end
    end

    // Cycle 0 is the cycle start is driven; caller must be at a falling edge.
    task automatic run_seq(input int rd_cyc, input bit succ, input logic [15:0] pat,
                           input int pat_len, input int bs_cyc);
        logic [SS*WW-1:0] got;
        bit seen_done;
        exp_q.delete();
        for (int i = 0; i < SS; i++) begin
            mem[i] = $urandom;
            exp_q.push_back(mem[i]);
        end
        o_envm_cyc = -1; o_envm_n = 0; o_ws_cyc = -1; o_ws_n = 0;
        o_rd_first = -1; n_rd = 0; o_wv_first = -1; o_wv_last = -1; n_wv = 0;
        n_rlv = 0; o_done_cyc = -1; n_ra = 0;
        o_fail = 1'bx; o_code = 2'bxx; o_fail_c1 = 1'bx; o_code_c1 = 2'bxx;
        seen_done = 1'b0;
        for (int k = 0; k < 80 && !seen_done; k++) begin
            if (k > 0) @(negedge clk);
            start            = (k == 0) || (k == bs_cyc);
            recovery_done    = (k == rd_cyc);
            recovery_success = succ;
            if (rd_cyc >= 0 && k > rd_cyc && (k - rd_cyc - 1) < pat_len)
                array_ready = pat[k - rd_cyc - 1];
            else
                array_ready = 1'b1;
            #1;
            if (k == 1) begin
                o_fail_c1 = fail;
                o_code_c1 = fail_code;
            end
            if (envm_wr_en) begin
                if (o_envm_cyc < 0) o_envm_cyc = k;
                o_envm_n++;
            end
            if (weight_start) begin
                if (o_ws_cyc < 0) o_ws_cyc = k;
                o_ws_n++;
            end
            if (buf_rd_en) begin
                vec++;
                if (buf_rd_addr !== AW'(n_rd)) begin
                    err++;
                    $display("FAIL buf_rd_addr cyc %0d: got %0d expected %0d", k, buf_rd_addr, n_rd);
                end
                if (o_rd_first < 0) o_rd_first = k;
                n_rd++;
            end
            vec++;
            if (weight_valid) begin
                if (exp_q.size() == 0) begin
                    err++;
                    $display("FAIL weight_row cyc %0d: got %h expected no row", k, input_weights);
                end else begin
                    got = exp_q.pop_front();
                    if (input_weights !== got) begin
                        err++;
                        $display("FAIL weight_row cyc %0d: got %h expected %h", k, input_weights, got);
                    end
                end
                if (o_wv_first < 0) o_wv_first = k;
                o_wv_last = k;
                n_wv++;
            end else if (input_weights !== '0) begin
                err++;
                $display("FAIL weights_idle cyc %0d: got %h expected 0", k, input_weights);
            end
            if (row_load_valid) n_rlv++;
            if (rd_cyc >= 0 && k > rd_cyc && (k - rd_cyc - 1) < pat_len && n_ra < 16) begin
                o_ra[n_ra] = int'(read_addr);
                n_ra++;
            end
            if (done) begin
                seen_done  = 1'b1;
                o_done_cyc = k;
                o_fail     = fail;
                o_code     = fail_code;
            end
        end
        start = 1'b0;
        recovery_done = 1'b0;
        if (!seen_done) begin
            vec++; err++;
            $display("FAIL done_wait: got no done expected done within 80 cycles");
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vec++;
        if ({busy, buf_rd_en, envm_wr_en, weight_start, weight_valid, row_load_valid,
             done, fail, fail_code, buf_rd_addr, read_addr} !== '0 || input_weights !== '0) begin
            err++;
            $display("FAIL reset_outputs: got busy=%b rd=%b done=%b fail=%b expected all 0",
                     busy, buf_rd_en, done, fail);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        run_seq(10, 1'b1, 16'h000F, 4, -1);
        vec++; if (o_envm_cyc !== 1 || o_envm_n !== 1) begin err++;
            $display("FAIL envm: got cyc %0d n %0d expected cyc 1 n 1", o_envm_cyc, o_envm_n); end
        vec++; if (o_ws_cyc !== 2 || o_ws_n !== 1) begin err++;
            $display("FAIL wstart: got cyc %0d n %0d expected cyc 2 n 1", o_ws_cyc, o_ws_n); end
        vec++; if (o_rd_first !== 3 || n_rd !== 4) begin err++;
            $display("FAIL buf_rd: got first %0d n %0d expected 3 / 4", o_rd_first, n_rd); end
        vec++; if (o_wv_first !== 4 || o_wv_last !== 7 || n_wv !== 4) begin err++;
            $display("FAIL wvalid: got %0d..%0d n %0d expected 4..7 n 4", o_wv_first, o_wv_last, n_wv); end
        for (int i = 0; i < 4; i++) begin
            vec++; if (o_ra[i] !== i) begin err++;
                $display("FAIL read_addr[%0d]: got %0d expected %0d", i, o_ra[i], i); end
        end
        vec++; if (n_rlv !== 4 || o_done_cyc !== 15) begin err++;
            $display("FAIL basic_done: got rlv %0d done %0d expected 4 / 15", n_rlv, o_done_cyc); end
        vec++; if (o_fail !== 1'b0 || o_code !== 2'b00) begin err++;
            $display("FAIL basic_fail: got %b/%b expected 0/00", o_fail, o_code); end
        @(negedge clk); #1;
        vec++; if (done !== 1'b0 || busy !== 1'b0 || read_addr !== '0) begin err++;
            $display("FAIL post_done: got done %b busy %b ra %0d expected 0 0 0", done, busy, read_addr); end
    endtask

    task automatic test_unrecoverable;
        @(negedge clk);
        run_seq(10, 1'b0, 16'h000F, 4, -1);
        vec++; if (n_rlv !== 0 || o_done_cyc !== 11 || n_wv !== 4) begin err++;
            $display("FAIL unrec_flow: got rlv %0d done %0d wv %0d expected 0 / 11 / 4", n_rlv, o_done_cyc, n_wv); end
        vec++; if (o_fail !== 1'b1 || o_code !== 2'b01) begin err++;
            $display("FAIL unrec_code: got %b/%b expected 1/01", o_fail, o_code); end
        repeat (3) @(negedge clk);
        #1;
        vec++; if (fail !== 1'b1 || fail_code !== 2'b01 || busy !== 1'b0) begin err++;
            $display("FAIL fail_hold: got %b/%b busy %b expected 1/01 busy 0", fail, fail_code, busy); end
    endtask

    task automatic test_timeout;
        @(negedge clk);
        run_seq(-1, 1'b1, 16'h0000, 0, -1);
        vec++; if (o_fail_c1 !== 1'b0 || o_code_c1 !== 2'b00) begin err++;
            $display("FAIL fail_clear: got %b/%b expected 0/00", o_fail_c1, o_code_c1); end
        vec++; if (o_done_cyc !== 24 || n_rlv !== 0) begin err++;
            $display("FAIL timeout_cyc: got done %0d rlv %0d expected 24 / 0", o_done_cyc, n_rlv); end
        vec++; if (o_fail !== 1'b1 || o_code !== 2'b10) begin err++;
            $display("FAIL timeout_code: got %b/%b expected 1/10", o_fail, o_code); end
    endtask

    task automatic test_done_at_timeout;
        @(negedge clk);
        run_seq(23, 1'b1, 16'h000F, 4, -1);
        vec++; if (o_done_cyc !== 28 || n_rlv !== 4) begin err++;
            $display("FAIL edge_done: got done %0d rlv %0d expected 28 / 4", o_done_cyc, n_rlv); end
        vec++; if (o_fail !== 1'b0 || o_code !== 2'b00) begin err++;
            $display("FAIL edge_code: got %b/%b expected 0/00", o_fail, o_code); end
    endtask

    task automatic test_early_done;
        // recovery_done pulsed during STREAM must be ignored, leading to timeout
        @(negedge clk);
        run_seq(5, 1'b0, 16'h0000, 0, -1);
        vec++; if (o_done_cyc !== 24 || o_code !== 2'b10) begin err++;
            $display("FAIL early_done: got done %0d code %b expected 24 / 10", o_done_cyc, o_code); end
    endtask

    task automatic test_ready_stall;
        int exp_ra [7];
        exp_ra = '{0, 1, 1, 1, 2, 3, 3};
        @(negedge clk);
        run_seq(10, 1'b1, 16'b1011001, 7, -1);
        for (int i = 0; i < 7; i++) begin
            vec++; if (o_ra[i] !== exp_ra[i]) begin err++;
                $display("FAIL stall_ra[%0d]: got %0d expected %0d", i, o_ra[i], exp_ra[i]); end
        end
        vec++; if (n_rlv !== 4 || o_done_cyc !== 18) begin err++;
            $display("FAIL stall_done: got rlv %0d done %0d expected 4 / 18", n_rlv, o_done_cyc); end
    endtask

    task automatic test_reset_mid_stream;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        vec++;
        if ({busy, buf_rd_en, envm_wr_en, weight_start, weight_valid, row_load_valid,
             done, fail, fail_code, buf_rd_addr, read_addr} !== '0 || input_weights !== '0) begin
            err++;
            $display("FAIL midreset: got busy=%b rd=%b addr=%0d wv=%b expected all 0",
                     busy, buf_rd_en, buf_rd_addr, weight_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        run_seq(10, 1'b1, 16'h000F, 4, -1);
        vec++; if (o_rd_first !== 3 || n_rd !== 4 || o_done_cyc !== 15) begin err++;
            $display("FAIL replay: got rd %0d n %0d done %0d expected 3 / 4 / 15", o_rd_first, n_rd, o_done_cyc); end
    endtask

    task automatic test_busy_start;
        @(negedge clk);
        run_seq(10, 1'b1, 16'h000F, 4, 12);
        vec++; if (o_done_cyc !== 15 || o_envm_n !== 1 || n_rlv !== 4) begin err++;
            $display("FAIL busy_start: got done %0d envm %0d rlv %0d expected 15 / 1 / 4", o_done_cyc, o_envm_n, n_rlv); end
        repeat (2) @(negedge clk);
        #1;
        vec++; if (busy !== 1'b0 || envm_wr_en !== 1'b0) begin err++;
            $display("FAIL busy_restart: got busy %b envm %b expected 0 0", busy, envm_wr_en); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_unrecoverable;
        test_timeout;
        test_done_at_timeout;
        test_early_done;
        test_ready_stall;
        test_reset_mid_stream;
        test_busy_start;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

`default_nettype wire
